// File: rtl/cla_pkg.sv
// Shared defaults and the lookahead carry helper for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH      = 32;
  localparam int unsigned CLA_GROUP      = 4;
  localparam int unsigned CLA_STAGES     = 2;
  localparam int unsigned CLA_NUM_GROUPS = CLA_WIDTH / CLA_GROUP;
  localparam int unsigned CLA_GPS        = CLA_NUM_GROUPS / CLA_STAGES;
  localparam int unsigned CLA_MAX_N      = 64;

  // Carry into every position of a generate/propagate vector: c[0]=cin, c[i+1]=g|p&c.
  function automatic logic [CLA_MAX_N:0] cla_group_carries(
    input logic [CLA_MAX_N-1:0] g,
    input logic [CLA_MAX_N-1:0] p,
    input logic                 cin
  );
    logic [CLA_MAX_N:0] c;
    c[0] = cin;
    for (int unsigned i = 0; i < CLA_MAX_N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit lookahead block: sum bits plus group generate/propagate.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum_c,
  output logic             g_c,
  output logic             p_c
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  assign g     = a & b;
  assign p     = a | b;
  assign c     = GROUP'(cla_group_carries(CLA_MAX_N'(g), CLA_MAX_N'(p), cin));
  assign sum_c = a ^ b ^ c;
  assign p_c   = &p;

  // Group generate is independent of cin, so the stage-level carry has no loop.
  always_comb begin
    g_c = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      g_c = g[i] | (p[i] & g_c);
    end
  end

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder with a global valid/ready stall.
// Optional signed-overflow output enabled by defining CLA_OVERFLOW_EN.
module cla_pipelined_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = CLA_WIDTH,
  parameter int unsigned GROUP  = CLA_GROUP,
  parameter int unsigned STAGES = CLA_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef CLA_OVERFLOW_EN
  output logic             o_overflow,
`endif
  output logic [WIDTH:0]   o_result
);

  localparam int unsigned NUM_GROUPS = WIDTH / GROUP;
  localparam int unsigned GPS        = NUM_GROUPS / STAGES;
  localparam int unsigned SW         = GPS * GROUP;
  localparam int unsigned CW         = GPS + 1;

  if (STAGES == 0 || GROUP == 0 || GROUP > CLA_MAX_N || (WIDTH % GROUP) != 0 ||
      (NUM_GROUPS % STAGES) != 0 || GPS > CLA_MAX_N) begin : g_cfg_err
    $error("cla_pipelined_adder: WIDTH must be a multiple of GROUP and WIDTH/GROUP a multiple of STAGES");
  end

  logic stage_en;

  assign stage_en = !o_valid | i_ready;
  assign o_ready  = stage_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = unsigned'(k) * SW;
    localparam int unsigned HI = LO + SW;

    logic [WIDTH-1:LO] a_cur;
    logic [WIDTH-1:LO] b_cur;
    logic              cin_cur;
    logic              valid_cur;
    logic [HI-1:0]     sum_next;
    logic [SW-1:0]     sum_new;
    logic [GPS-1:0]    grp_g;
    logic [GPS-1:0]    grp_p;
    logic [GPS:0]      grp_c;
    logic [HI-1:0]     sum_q;
    logic              carry_q;
    logic              valid_q;

    // Stage 0 takes the ports; later stages take the previous stage's registers.
    if (k == 0) begin : g_src
      assign a_cur     = i_add1;
      assign b_cur     = i_add2;
      assign cin_cur   = i_carry;
      assign valid_cur = i_valid;
      assign sum_next  = sum_new;
    end else begin : g_src
      assign a_cur     = g_stage[k-1].g_rem.a_q;
      assign b_cur     = g_stage[k-1].g_rem.b_q;
      assign cin_cur   = g_stage[k-1].carry_q;
      assign valid_cur = g_stage[k-1].valid_q;
      assign sum_next  = {sum_new, g_stage[k-1].sum_q};
    end

    assign grp_c = CW'(cla_group_carries(CLA_MAX_N'(grp_g), CLA_MAX_N'(grp_p), cin_cur));

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_group (
        .a     (a_cur[LO + j*GROUP +: GROUP]),
        .b     (b_cur[LO + j*GROUP +: GROUP]),
        .cin   (grp_c[j]),
        .sum_c (sum_new[j*GROUP +: GROUP]),
        .g_c   (grp_g[j]),
        .p_c   (grp_p[j])
      );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (stage_en) begin
        valid_q <= valid_cur;
        carry_q <= grp_c[GPS];
        sum_q   <= sum_next;
      end
    end

    // Operand bits not yet added travel with the partial sum.
    if (unsigned'(k) + 1 < STAGES) begin : g_rem
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (stage_en) begin
          a_q <= a_cur[WIDTH-1:HI];
          b_q <= b_cur[WIDTH-1:HI];
        end
      end
    end

`ifdef CLA_OVERFLOW_EN
    // Sign bits reach the last stage inside the remaining operand slices.
    if (unsigned'(k) + 1 == STAGES) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q <= 1'b0;
        end else if (stage_en) begin
          ovf_q <= (a_cur[WIDTH-1] == b_cur[WIDTH-1]) & (sum_new[SW-1] != a_cur[WIDTH-1]);
        end
      end
    end
`endif
  end

  assign o_valid  = g_stage[STAGES-1].valid_q;
  assign o_result = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].sum_q};
`ifdef CLA_OVERFLOW_EN
  assign o_overflow = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
